// File: rtl/rom_programmer.sv
// rom_programmer: streams source words into a ROM over a shared bus, unlocking write
// protection for the run and relocking it afterwards.
// Build option: define ROM_PROGRAMMER_VERIFY_EN to read back and compare every word.
module rom_programmer #(
    parameter logic [15:0] ROM_BASE = 16'h0000,
    parameter int unsigned DEPTH    = 32768
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] count,
    input  logic        src_valid,
    input  logic [15:0] src_data,
    output logic        src_ready,
    output logic        bus_req,
    input  logic        bus_grant,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_wdata,
    output logic        bus_we,
    output logic        bus_re,
    input  logic [15:0] bus_rdata,
    output logic        write_protect,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] err_addr
);

`ifdef ROM_PROGRAMMER_VERIFY_EN
    typedef enum logic [3:0] {
        StIdle, StReq, StUnlock, StFetch, StWrite, StRead, StCmp, StLock, StFail
    } state_e;
`else
    typedef enum logic [3:0] {
        StIdle, StReq, StUnlock, StFetch, StWrite, StLock
    } state_e;
`endif

    localparam logic [16:0] DepthLim = 17'(DEPTH);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] index_q, index_d;
    logic [15:0] word_q, word_d;
    logic        zdone_q, zdone_d;  // done pulse for a zero-length run
    logic [15:0] addr;
    logic [15:0] index_inc;

`ifdef ROM_PROGRAMMER_VERIFY_EN
    logic        error_q, error_d;
    logic [15:0] err_addr_q, err_addr_d;

    assign error    = error_q;
    assign err_addr = err_addr_q;
`else
    logic unused_rdata;

    assign unused_rdata = ^bus_rdata;
    assign error        = 1'b0;
    assign err_addr     = 16'h0000;
`endif

    assign busy = (state_q != StIdle);

    // Next-state, datapath updates and bus/handshake outputs.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        index_d       = index_q;
        word_d        = word_q;
        zdone_d       = 1'b0;
`ifdef ROM_PROGRAMMER_VERIFY_EN
        error_d       = error_q;
        err_addr_d    = err_addr_q;
`endif
        addr          = ROM_BASE + index_q;
        index_inc     = index_q + 16'd1;
        src_ready     = 1'b0;
        bus_req       = 1'b0;
        bus_we        = 1'b0;
        bus_re        = 1'b0;
        bus_addr      = 16'h0000;
        bus_wdata     = 16'h0000;
        write_protect = 1'b1;
        done          = zdone_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (count != 16'h0000) begin
                        cnt_d   = ({1'b0, count} > DepthLim) ? DepthLim[15:0] : count;
                        index_d = 16'h0000;
`ifdef ROM_PROGRAMMER_VERIFY_EN
                        error_d    = 1'b0;
                        err_addr_d = 16'h0000;
`endif
                        state_d = StReq;
                    end else begin
                        zdone_d = 1'b1;
                    end
                end
            end
            StReq: begin
                bus_req = 1'b1;
                if (bus_grant) state_d = StUnlock;
            end
            StUnlock: begin
                bus_req       = 1'b1;
                write_protect = 1'b0;
                state_d       = StFetch;
            end
            StFetch: begin
                bus_req       = 1'b1;
                write_protect = 1'b0;
                src_ready     = 1'b1;
                if (src_valid) begin
                    word_d  = src_data;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                bus_req       = 1'b1;
                write_protect = 1'b0;
                bus_addr      = addr;
                bus_wdata     = word_q;
                bus_we        = bus_grant;
                if (bus_grant) begin
`ifdef ROM_PROGRAMMER_VERIFY_EN
                    state_d = StRead;
`else
                    index_d = index_inc;
                    state_d = (index_inc == cnt_q) ? StLock : StFetch;
`endif
                end
            end
`ifdef ROM_PROGRAMMER_VERIFY_EN
            StRead: begin
                bus_req       = 1'b1;
                write_protect = 1'b0;
                bus_addr      = addr;
                bus_re        = bus_grant;
                if (bus_grant) state_d = StCmp;
            end
            StCmp: begin
                bus_req       = 1'b1;
                write_protect = 1'b0;
                if (bus_rdata == word_q) begin
                    index_d = index_inc;
                    state_d = (index_inc == cnt_q) ? StLock : StFetch;
                end else begin
                    error_d    = 1'b1;
                    err_addr_d = addr;
                    state_d    = StFail;
                end
            end
            StFail: begin
                state_d = StIdle;
            end
`endif
            StLock: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort beats everything: suppress strobes now, drop to idle next cycle.
        if (abort && (state_q != StIdle)) begin
            state_d   = StIdle;
            index_d   = index_q;
            word_d    = word_q;
            src_ready = 1'b0;
            bus_we    = 1'b0;
            bus_re    = 1'b0;
            done      = 1'b0;
`ifdef ROM_PROGRAMMER_VERIFY_EN
            error_d    = error_q;
            err_addr_d = err_addr_q;
`endif
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= 16'h0000;
            index_q    <= 16'h0000;
            word_q     <= 16'h0000;
            zdone_q    <= 1'b0;
`ifdef ROM_PROGRAMMER_VERIFY_EN
            error_q    <= 1'b0;
            err_addr_q <= 16'h0000;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            index_q    <= index_d;
            word_q     <= word_d;
            zdone_q    <= zdone_d;
`ifdef ROM_PROGRAMMER_VERIFY_EN
            error_q    <= error_d;
            err_addr_q <= err_addr_d;
`endif
        end
    end

endmodule
